// File: rtl/neuron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : neuron_pkg                                             |
// | Description : Shared widths, default memory map and FSM state        |
// |               encoding for the neuron MAC engine.                    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package neuron_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int ACC_W  = 20;

  // Default neuron memory map.
  localparam int DEF_INPUT_BASE  = 0;
  localparam int DEF_WEIGHT_BASE = 4;
  localparam int DEF_OUTPUT_ADDR = 20;
  localparam int MEM_DEPTH       = 40;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_X = 3'd1,
    ST_READ_W = 3'd2,
    ST_ACT    = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/neuron_activation.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : neuron_activation                                      |
// | Description : Combinational shift-and-saturate activation, mapping   |
// |               the 20-bit accumulator onto an 8-bit neuron output.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   acc_i : accumulator value (unsigned)                               |
// |   y_o   : min(acc_i >> SHIFT, 255)                                   |
// +----------------------------------------------------------------------+
module neuron_activation
  import neuron_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] y_o
);

  logic [ACC_W-1:0] w_shifted;

  assign w_shifted = acc_i >> SHIFT;

  // Any bit set above the output width means the value exceeds 255.
  assign y_o = (|w_shifted[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_shifted[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/neuron_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : neuron_mac_engine                                      |
// | Description : Sequencer and MAC datapath computing one neuron output |
// |               from the neuron RAM and writing the result back.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
// | Ports                                                                |
// |   clk, rst        : clock, synchronous active-high reset             |
// |   start_i         : start request, sampled only in IDLE              |
// |   busy_o          : computation in progress (through DONE)           |
// |   done_o          : one-cycle completion pulse                       |
// |   result_o        : last neuron output                               |
// |   oe_o            : RAM read enable                                  |
// |   read_address_o  : RAM read address                                 |
// |   read_data_i     : RAM read data (combinational, same cycle)        |
// |   wre_o           : RAM write enable                                 |
// |   write_address_o : RAM write address (holds after WRITE)            |
// |   write_data_o    : RAM write data (holds after WRITE)               |
// +----------------------------------------------------------------------+
module neuron_mac_engine
  import neuron_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int INPUT_BASE  = DEF_INPUT_BASE,
  parameter int WEIGHT_BASE = DEF_WEIGHT_BASE,
  parameter int OUTPUT_ADDR = DEF_OUTPUT_ADDR,
  parameter int SHIFT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              oe_o,
  output logic [ADDR_W-1:0] read_address_o,
  input  logic [DATA_W-1:0] read_data_i,
  output logic              wre_o,
  output logic [ADDR_W-1:0] write_address_o,
  output logic [DATA_W-1:0] write_data_o
);

  localparam int               IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [2*DATA_W-1:0] w_product;
  logic [DATA_W-1:0]   w_act_y;

  // Operands widened so the full 16-bit product is kept.
  assign w_product = {{DATA_W{1'b0}}, x_q} * {{DATA_W{1'b0}}, read_data_i};

  neuron_activation #(
    .SHIFT (SHIFT)
  ) u_activation (
    .acc_i (acc_q),
    .y_o   (w_act_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      idx_q    <= idx_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    acc_d    = acc_q;
    result_d = result_q;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_READ_X;
        end
      end
      ST_READ_X: begin
        x_d     = read_data_i;
        state_d = ST_READ_W;
      end
      ST_READ_W: begin
        acc_d = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, w_product};
        if (idx_q == LAST_IDX) begin
          state_d = ST_ACT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_READ_X;
        end
      end
      ST_ACT: begin
        result_d = w_act_y;
        wdata_d  = w_act_y;
        // Loaded here so the address is already stable during WRITE.
        waddr_d  = ADDR_W'(OUTPUT_ADDR);
        state_d  = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    oe_o           = 1'b0;
    read_address_o = '0;
    wre_o          = 1'b0;
    done_o         = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    case (state_q)
      ST_READ_X: begin
        oe_o           = 1'b1;
        read_address_o = ADDR_W'(INPUT_BASE) + ADDR_W'(idx_q);
      end
      ST_READ_W: begin
        oe_o           = 1'b1;
        read_address_o = ADDR_W'(WEIGHT_BASE) + ADDR_W'(idx_q);
      end
      ST_WRITE: wre_o  = 1'b1;
      ST_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign result_o        = result_q;
  assign write_data_o    = wdata_q;
  assign write_address_o = waddr_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_neuron_mac_engine                                   |
// | Description : Scoreboard bench for neuron_mac_engine. Four instances |
// |               share one RAM model: (N=4,S=0) (N=4,S=2) (N=4,S=6)     |
// |               and (N=1,S=0). Only one instance runs at a time.       |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_neuron_mac_engine;

  localparam int NI       = 4;
  localparam int OUT_ADDR = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [NI];
  logic       busy  [NI];
  logic       done  [NI];
  logic       oe    [NI];
  logic       wre   [NI];
  logic [7:0] result[NI];
  logic [7:0] raddr [NI];
  logic [7:0] rdata [NI];
  logic [7:0] waddr [NI];
  logic [7:0] wdata [NI];

  logic [7:0] ram [0:255];
  logic       tb_we;
  logic [7:0] tb_wa, tb_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int n_of(input int k);
    return (k == 3) ? 1 : 4;
  endfunction

  function automatic int sh_of(input int k);
    return (k == 1) ? 2 : ((k == 2) ? 6 : 0);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    neuron_mac_engine #(
      .N_INPUTS    ((g == 3) ? 1 : 4),
      .INPUT_BASE  (0),
      .WEIGHT_BASE (4),
      .OUTPUT_ADDR (OUT_ADDR),
      .SHIFT       ((g == 1) ? 2 : ((g == 2) ? 6 : 0))
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start_i         (start[g]),
      .busy_o          (busy[g]),
      .done_o          (done[g]),
      .result_o        (result[g]),
      .oe_o            (oe[g]),
      .read_address_o  (raddr[g]),
      .read_data_i     (rdata[g]),
      .wre_o           (wre[g]),
      .write_address_o (waddr[g]),
      .write_data_o    (wdata[g])
    );
    assign rdata[g] = ram[raddr[g]];
  end

  // RAM: combinational read, write committed on the clock edge.
  always @(posedge clk) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    for (int k = 0; k < NI; k++) begin
      if (wre[k]) ram[waddr[k]] <= wdata[k];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int inst;
    int res;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   wre_cnt[NI];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic unexpected(input string name, input int k);
    total++;
    $display("FAIL %s: instance %0d raised it with no matching expectation (pending %0d)",
             name, k, sb.size());
  endtask

  // Reference: sum of products, shift, saturate -- straight from the rules.
  function automatic int model(input int n, input int sh);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(ram[i]) * longint'(ram[4 + i]);
    acc = acc >>> sh;
    return (acc > 255) ? 255 : int'(acc);
  endfunction

  // Monitor: compares whatever the DUTs present against the queue head.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (wre[k] === 1'b1) begin
        wre_cnt[k]++;
        if (sb.size() == 0 || sb[0].inst != k) unexpected("wre", k);
        else begin
          check("write_address", int'(waddr[k]), OUT_ADDR);
          check("write_data", int'(wdata[k]), sb[0].res);
        end
      end
      if (done[k] === 1'b1) begin
        if (sb.size() == 0 || sb[0].inst != k) unexpected("done", k);
        else begin
          e = sb.pop_front();
          check("result", int'(result[k]), e.res);
          check("done_cycle", cyc, e.cyc);
          check("ram_out", int'(ram[OUT_ADDR]), e.res);
          check("wre_cycles", wre_cnt[k], 1);
        end
        wre_cnt[k] = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic load_image(input logic [3:0][7:0] x, input logic [3:0][7:0] w);
    for (int i = 0; i < 4; i++) begin
      poke(8'(i), x[i]);
      poke(8'(4 + i), w[i]);
    end
  endtask

  // Issue a start to instance k; leaves start high if hold is set.
  task automatic run(input int k, input bit hold);
    int guard = 0;
    @(negedge clk);
    while (busy[k] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy[k]) begin
      total++;
      $display("FAIL idle_wait: instance %0d still busy after %0d cycles", k, guard);
    end
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{k, model(n_of(k), sh_of(k)), cyc + 2 * n_of(k) + 2});
    if (!hold) start[k] = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d expectations still pending", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    tb_we = 1'b0;
    tb_wa = '0;
    tb_wd = '0;
    for (int k = 0; k < NI; k++) begin
      start[k]   = 1'b0;
      wre_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("rst_busy",   int'(busy[k]),   0);
      check("rst_done",   int'(done[k]),   0);
      check("rst_oe",     int'(oe[k]),     0);
      check("rst_wre",    int'(wre[k]),    0);
      check("rst_raddr",  int'(raddr[k]),  0);
      check("rst_waddr",  int'(waddr[k]),  0);
      check("rst_wdata",  int'(wdata[k]),  0);
      check("rst_result", int'(result[k]), 0);
    end
    rst = 1'b0;

    // Default image: 114, 114>>2=28, N=1 gives 40.
    load_image({8'd2, 8'd5, 8'd11, 8'd10}, {8'd2, 8'd3, 8'd5, 8'd4});
    run(0, 1'b0); drain();
    run(1, 1'b0); drain();
    run(3, 1'b0); drain();

    // Saturation image: 260100 -> 255; >>6 = 4064 -> 255.
    load_image({4{8'd255}}, {4{8'd255}});
    run(0, 1'b0); drain();
    run(2, 1'b0); drain();

    // Random images on random instances.
    for (int t = 0; t < 8; t++) begin
      load_image({8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)},
                 {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)});
      run(int'($urandom_range(0, 3)), 1'b0);
      drain();
    end

    // start held high: back-to-back runs, 2N+4 edges apart.
    load_image({8'd2, 8'd5, 8'd11, 8'd10}, {8'd2, 8'd3, 8'd5, 8'd4});
    run(0, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    sb.push_back('{0, 114, cyc + 10});
    start[0] = 1'b0;
    drain();

    // start pulse during READ_W must not queue a second run.
    run(0, 1'b0);
    @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    drain();
    repeat (15) @(negedge clk);

    // Reset in cycle 5 after E0: no write, outputs back to reset values.
    poke(8'(OUT_ADDR), 8'h5A);
    run(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",   int'(busy[0]),   0);
    check("midrst_oe",     int'(oe[0]),     0);
    check("midrst_wre",    int'(wre[0]),    0);
    check("midrst_result", int'(result[0]), 0);
    repeat (15) @(negedge clk);
    check("midrst_ram", int'(ram[OUT_ADDR]), 8'h5A);
    run(0, 1'b0); drain();

    // rst and start on the same edge: start is dropped.
    @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("rst_start_busy", int'(busy[0]), 0);
    repeat (15) @(negedge clk);

    check("pending_at_end", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
